alu_sequencer: RTL and testbench

- Front-end controller for the 4-bit ALU (ULA) on the DE2 board.
- Turns two raw pushbuttons into clean single-cycle press events and steps an operand-entry state machine: operand A, then operand B, then operation.
- On confirmation, holds a/b/op stable for the ALU, waits the ALU latency, captures both result nibbles, and shows them until the next cycle.
- Replaces the ad-hoc per-KEY posedge registers with one synchronous, resettable controller clocked by CLOCK_50.

---
 rtl/alu_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: front-end controller for the 4-bit DE2 ALU.
// Conditions two raw active-low pushbuttons into single-cycle press events
// and steps the operand-entry flow A -> B -> OP -> EXEC -> SHOW.
// After confirmation it holds a/b/op stable, waits out the ALU latency,
// captures both result nibbles and keeps them on display until the next
// capture or reset.
module alu_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_OPERAND     = 9,
  parameter int ALU_LATENCY     = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       key_inc,
  input  logic       key_next,
  input  logic [3:0] result1_in,
  input  logic [3:0] result2_in,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [1:0] op,
  output logic [3:0] res1,
  output logic [3:0] res2,
  output logic [2:0] state,
  output logic       busy,
  output logic       done
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1, so this width
  // is always sufficient (and at least one bit for tiny test values).
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int LAT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LATENCY);
  localparam logic [3:0]       MAX_OP   = 4'(MAX_OPERAND);

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_ENTER_OP = 3'd2,
    ST_EXEC     = 3'd3,
    ST_SHOW     = 3'd4
  } state_t;

  // Bit 0 is the increment key, bit 1 is the next key.
  logic [1:0] w_key_raw;
  logic [1:0] w_press;
  logic       w_inc;
  logic       w_next;

  assign w_key_raw = {key_next, key_inc};
  assign w_inc     = w_press[0];
  assign w_next    = w_press[1];

  // Per-key conditioning: 2-FF synchronizer, stability counter, and a
  // debounced level where 1 means pressed. The press event is decoded
  // combinationally on the same cycle the debounced level flips to pressed,
  // so the FSM reacts exactly 2+DEBOUNCE_CYCLES cycles after the raw edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic             r_sync1;
      logic             r_sync2;
      logic             r_deb;
      logic [CNT_W-1:0] r_cnt;
      logic             w_flip;

      assign w_flip = (r_sync2 != r_deb) && (r_cnt == CNT_LAST);

      // Synchronize the inverted raw key and qualify level changes.
      always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_deb   <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= ~w_key_raw[gi];
          r_sync2 <= r_sync1;
          if (r_sync2 == r_deb) begin
            r_cnt <= '0;
          end else if (w_flip) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      // Only a released->pressed flip is an event; release is silent.
      assign w_press[gi] = w_flip && r_sync2;
    end
  endgenerate

  state_t           r_state;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [1:0]       r_op;
  logic [3:0]       r_res1;
  logic [3:0]       r_res2;
  logic             r_busy;
  logic             r_done;
  logic [LAT_W-1:0] r_lat;

  // Operand-entry sequencer with registered outputs; next beats inc.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state <= ST_ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res1  <= '0;
      r_res2  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lat   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_ENTER_A: begin
          if (w_next) begin
            r_state <= ST_ENTER_B;
          end else if (w_inc) begin
            r_a <= (r_a == MAX_OP) ? 4'd0 : r_a + 4'd1;
          end
        end
        ST_ENTER_B: begin
          if (w_next) begin
            r_state <= ST_ENTER_OP;
          end else if (w_inc) begin
            r_b <= (r_b == MAX_OP) ? 4'd0 : r_b + 4'd1;
          end
        end
        ST_ENTER_OP: begin
          if (w_next) begin
            r_state <= ST_EXEC;
            r_lat   <= LAT_LOAD;
            r_busy  <= 1'b1;
          end else if (w_inc) begin
            r_op <= r_op + 2'd1;
          end
        end
        ST_EXEC: begin
          // Key events are dropped here; a/b/op stay frozen for the ALU.
          if (r_lat == '0) begin
            r_res1  <= result1_in;
            r_res2  <= result2_in;
            r_state <= ST_SHOW;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        ST_SHOW: begin
          // Values are retained so the user edits from the last operands.
          if (w_next) begin
            r_state <= ST_ENTER_A;
          end
        end
        default: begin
          r_state <= ST_ENTER_A;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a     = r_a;
  assign b     = r_b;
  assign op    = r_op;
  assign res1  = r_res1;
  assign res2  = r_res2;
  assign state = r_state;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with short debounce.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_inc = 1'b1;
  logic       key_next = 1'b1;
  logic [3:0] result1_in;
  logic [3:0] result2_in;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] op;
  logic [3:0] res1;
  logic [3:0] res2;
  logic [2:0] state;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  alu_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .MAX_OPERAND    (9),
    .ALU_LATENCY    (1)
  ) dut (
    .CLOCK_50  (clk),
    .reset_n   (reset_n),
    .key_inc   (key_inc),
    .key_next  (key_next),
    .result1_in(result1_in),
    .result2_in(result2_in),
    .a         (a),
    .b         (b),
    .op        (op),
    .res1      (res1),
    .res2      (res2),
    .state     (state),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Small ALU stand-in: op 2 gives a-b and op[1] as result2.
  assign result1_in = (op == 2'd2) ? (a - b) : (a + b);
  assign result2_in = {3'b000, op[1]};

  // Count done pulses away from the active edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("  ok %s = %0d", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One clean press/release: event lands on the 6th tick of the low phase.
  task automatic press(input bit do_next, input bit do_inc);
    key_next = ~do_next;
    key_inc  = ~do_inc;
    tick(7);
    key_next = 1'b1;
    key_inc  = 1'b1;
    tick(7);
  endtask

  initial begin
    // Reset with both keys held.
    reset_n  = 1'b0;
    key_inc  = 1'b0;
    key_next = 1'b0;
    tick(3);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_op", op, 0);
    check("rst_res1", res1, 0);
    check("rst_res2", res2, 0);
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n  = 1'b1;
    key_next = 1'b1;
    tick(5);
    check("held_a_before", a, 0);
    tick(1);
    check("held_a_at6", a, 1);
    tick(4);
    check("held_a_single", a, 1);
    key_inc = 1'b1;
    tick(7);

    // Bounce: 2-cycle toggling, then a solid press.
    for (int i = 0; i < 20; i++) begin
      key_inc = i[0];
      tick(1);
    end
    check("bounce_a_mid", a, 1);
    key_inc = 1'b0;
    tick(10);
    key_inc = 1'b1;
    tick(7);
    check("bounce_a", a, 2);
    // 3-cycle glitch is rejected.
    key_inc = 1'b0;
    tick(3);
    key_inc = 1'b1;
    tick(7);
    check("glitch_a", a, 2);

    // Wrap of a from 0 through 9 back to 0.
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("rst2_a", a, 0);
    for (int i = 1; i <= 10; i++) begin
      press(1'b0, 1'b1);
      check($sformatf("wrap_a_%0d", i), a, (i == 10) ? 0 : i);
    end

    // a = 7, then move to ENTER_B.
    repeat (7) press(1'b0, 1'b1);
    check("a_set", a, 7);
    press(1'b1, 1'b0);
    check("state_b", state, 1);

    // b = 3, then simultaneous inc+next.
    repeat (3) press(1'b0, 1'b1);
    check("b_set", b, 3);
    press(1'b1, 1'b1);
    check("simul_state", state, 2);
    check("simul_b", b, 3);

    // op wraps 1,2,3,0 then set to 2.
    for (int i = 1; i <= 4; i++) begin
      press(1'b0, 1'b1);
      check($sformatf("wrap_op_%0d", i), op, i % 4);
    end
    repeat (2) press(1'b0, 1'b1);
    check("op_set", op, 2);

    // Execute; an inc event arrives one cycle later, inside EXEC.
    done_cnt = 0;
    key_next = 1'b0;
    tick(1);
    key_inc = 1'b0;
    tick(5);
    check("exec_state", state, 3);
    check("exec_busy", busy, 1);
    check("exec_done", done, 0);
    tick(1);
    check("exec2_state", state, 3);
    check("exec2_res1", res1, 0);
    check("exec2_a", a, 7);
    check("exec2_op", op, 2);
    tick(1);
    check("show_state", state, 4);
    check("show_res1", res1, 4);
    check("show_res2", res2, 1);
    check("show_done", done, 1);
    check("show_busy", busy, 0);
    tick(1);
    check("show_done_clr", done, 0);
    check("show_res1_hold", res1, 4);
    key_next = 1'b1;
    key_inc  = 1'b1;
    tick(7);
    check("done_pulses", done_cnt, 1);
    check("exec_frozen_a", a, 7);
    check("exec_frozen_b", b, 3);

    // inc ignored in SHOW, next returns to ENTER_A keeping values.
    press(1'b0, 1'b1);
    check("show_inc_state", state, 4);
    check("show_inc_a", a, 7);
    press(1'b1, 1'b0);
    check("ret_state", state, 0);
    check("ret_a", a, 7);
    check("ret_b", b, 3);
    check("ret_op", op, 2);
    check("ret_res1", res1, 4);

    // Reset in the middle of EXEC.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("pre_exec_state", state, 2);
    done_cnt = 0;
    key_next = 1'b0;
    tick(6);
    check("mid_exec_state", state, 3);
    reset_n  = 1'b0;
    key_next = 1'b1;
    tick(1);
    check("mid_rst_state", state, 0);
    check("mid_rst_a", a, 0);
    check("mid_rst_res1", res1, 0);
    check("mid_rst_busy", busy, 0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    check("post_rst_state", state, 0);
    check("post_rst_res1", res1, 0);
    check("post_rst_res2", res2, 0);
    check("post_rst_done_pulses", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
